// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
// Shared definitions for the tick controller: FSM state encodings, the width
// of the speed-select code, and the prescaler period helper used to build the
// terminal-count constants at elaboration time.
// -----------------------------------------------------------------------------
package tick_pkg;

  // Width of the speed code taken from the board switches.
  localparam int SPEED_W = 2;

  typedef logic [SPEED_W-1:0] speed_t;

  // RUN generates periodic ticks; PAUSE waits for single-step presses.
  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  // Prescaler period in clock cycles for a given speed code:
  // the tick rate doubles with each step of the code.
  function automatic int unsigned tick_period(input int unsigned clk_hz,
                                              input int unsigned tick_hz,
                                              input speed_t      s);
    return clk_hz / (tick_hz << s);
  endfunction

endpackage : tick_pkg

// File: rtl/tick_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Accepts a new key level only after it has differed from the current accepted
// level for DB_CYCLES consecutive cycles. A falling accepted level (key
// pressed, active-low) produces a one-cycle press pulse; release is silent.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   raw      in   already-synchronised key input (active-low)
//   level    out  accepted (debounced) key level, 1 = released
//   press    out  one-cycle pulse when level goes 1 -> 0
// -----------------------------------------------------------------------------
module debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of the order of statements or blocks.
      press <= 1'b0;
      if (raw == level) begin
        // Any agreeing cycle restarts the stability window.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DB_CYCLES-th consecutive mismatch: accept the new level.
        cnt   <= '0;
        level <= raw;
        press <= ~raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : debounce

// File: rtl/tick_ctrl.sv
// -----------------------------------------------------------------------------
// tick_ctrl
// Generates a single-cycle count enable (tick) for the downstream counter.
// RUN: periodic ticks at TICK_HZ << speed. PAUSE: ticks only on step presses.
// The run/pause key toggles between the two states.
//
// Ports:
//   CLOCK_50    in   system clock, all logic on the rising edge
//   V_KEY[0]    in   reset, active-low, asynchronous assert, synchronised release
//   V_KEY[1]    in   step key, active-low, raw
//   V_KEY[2]    in   run/pause toggle key, active-low, raw
//   V_SW[1:0]   in   speed code s, tick rate = TICK_HZ << s
//   tick        out  registered one-cycle count-enable pulse
//   running     out  registered, 1 while in RUN
// -----------------------------------------------------------------------------
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int          DB_CYCLES = 500000
) (
  input  logic         CLOCK_50,
  input  logic [2:0]   V_KEY,
  input  logic [1:0]   V_SW,
  output logic         tick,
  output logic         running
);

  // ---------------------------------------------------------------------------
  // Prescaler sizing: wide enough for the slowest period (speed code 0).
  // ---------------------------------------------------------------------------
  localparam int unsigned RATIO = CLK_HZ / TICK_HZ;
  localparam int          PRE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [PRE_W-1:0] LAST_S0 = PRE_W'(tick_period(CLK_HZ, TICK_HZ, 2'd0) - 1);
  localparam logic [PRE_W-1:0] LAST_S1 = PRE_W'(tick_period(CLK_HZ, TICK_HZ, 2'd1) - 1);
  localparam logic [PRE_W-1:0] LAST_S2 = PRE_W'(tick_period(CLK_HZ, TICK_HZ, 2'd2) - 1);
  localparam logic [PRE_W-1:0] LAST_S3 = PRE_W'(tick_period(CLK_HZ, TICK_HZ, 2'd3) - 1);

  // ---------------------------------------------------------------------------
  // Reset: asserts immediately, releases two edges after the key goes high so
  // every flop leaves reset on the same clean edge.
  // ---------------------------------------------------------------------------
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge CLOCK_50 or negedge V_KEY[0]) begin
    if (!V_KEY[0]) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchronisers. Keys idle high (released), switches idle at speed 0.
  // ---------------------------------------------------------------------------
  logic [1:0] key_meta;
  logic [1:0] key_sync;
  speed_t     sw_meta;
  speed_t     sw_sync;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= V_KEY[2:1];
      key_sync <= key_meta;
      sw_meta  <= V_SW;
      sw_sync  <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Key debouncers.
  // ---------------------------------------------------------------------------
  logic step_level;
  logic step_press;
  logic toggle_level;
  logic toggle_press;

  debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clock   (CLOCK_50),
    .reset_n (rst_n),
    .raw     (key_sync[0]),
    .level   (step_level),
    .press   (step_press)
  );

  debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_toggle_db (
    .clock   (CLOCK_50),
    .reset_n (rst_n),
    .raw     (key_sync[1]),
    .level   (toggle_level),
    .press   (toggle_press)
  );

  // A press pulse always coincides with the key being accepted as held.
  assert property (@(posedge CLOCK_50) disable iff (!rst_n) step_press |-> !step_level);
  assert property (@(posedge CLOCK_50) disable iff (!rst_n) toggle_press |-> !toggle_level);

  // ---------------------------------------------------------------------------
  // Terminal count for the current speed, and speed-change detection.
  // The change is seen one edge early (meta vs sync) so the prescaler clears on
  // the same edge the new speed code takes effect.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] presc_last;
  logic             speed_change;
  logic             terminal;

  always_comb begin
    // NOTE: default first so every path assigns presc_last and no latch is
    // inferred for combinational outputs.
    presc_last = LAST_S0;
    case (sw_sync)
      2'd1:    presc_last = LAST_S1;
      2'd2:    presc_last = LAST_S2;
      2'd3:    presc_last = LAST_S3;
      default: presc_last = LAST_S0;
    endcase
  end

  assign speed_change = (sw_meta != sw_sync);
  assign terminal     = (presc == presc_last);

  // ---------------------------------------------------------------------------
  // Run/pause FSM with prescaler and registered outputs.
  // ---------------------------------------------------------------------------
  state_t state;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      running <= 1'b1;
      tick    <= 1'b0;
      presc   <= '0;
    end else begin
      tick <= 1'b0;
      case (state)
        RUN: begin
          if (speed_change) begin
            // New period starts from zero; the old terminal count is abandoned.
            presc <= '0;
          end else if (terminal) begin
            presc <= '0;
            tick  <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
          // A tick due on this edge is still emitted when pausing.
          if (toggle_press) begin
            state   <= PAUSE;
            running <= 1'b0;
            presc   <= '0;
          end
        end

        PAUSE: begin
          presc <= '0;
          // Toggle has priority; a simultaneous step is discarded.
          if (toggle_press) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step_press) begin
            tick <= 1'b1;
          end
        end

        default: begin
          state   <= RUN;
          running <= 1'b1;
          presc   <= '0;
        end
      endcase
    end
  end

endmodule : tick_ctrl

// File: tb/tb_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_ctrl
// Directed bench for tick_ctrl with CLK_HZ=1000, TICK_HZ=10, DB_CYCLES=4
// (periods 100/50/25/12). A per-edge behavioural model predicts tick/running
// from raw input history and a tick schedule; a negedge process compares the
// DUT against it every cycle, and the directed sequence pins key latencies and
// periods with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_tick_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 10;
  localparam int DB      = 4;

  logic       clk = 1'b0;
  logic [2:0] key;
  logic [1:0] sw;
  logic       tick;
  logic       running;

  tick_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DB_CYCLES (DB)
  ) dut (
    .CLOCK_50 (clk),
    .V_KEY    (key),
    .V_SW     (sw),
    .tick     (tick),
    .running  (running)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int period(input int s);
    return CLK_HZ / (TICK_HZ << s);
  endfunction

  int         cyc = 0;         // posedge index
  int         rel = 0;         // edges seen with reset key released (saturates at 3)
  logic [1:0] kh [8] = '{default: 2'b11};  // synchroniser-visible key history
  logic [1:0] sh [8] = '{default: 2'b00};  // synchroniser-visible switch history
  bit         m_run  = 1'b1;
  bit         m_tick = 1'b0;
  int         next_tick = 0;
  bit         lvl [2] = '{1'b1, 1'b1};     // [0] step, [1] toggle
  bit         prs [2] = '{1'b0, 1'b0};     // presses accepted on the previous edge
  logic [1:0] s_now, s_old;
  bit         flip;

  function automatic int ri(input int d);
    return (cyc - d + 64) % 8;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (key[0] == 1'b0) rel = 0;
    else if (rel < 3)   rel++;

    if (rel < 3) begin
      // Internal reset still held on this edge.
      kh[ri(0)] = 2'b11;
      sh[ri(0)] = 2'b00;
      m_run  = 1'b1;
      m_tick = 1'b0;
      lvl    = '{1'b1, 1'b1};
      prs    = '{1'b0, 1'b0};
      if (rel == 2) next_tick = cyc + period(0);
    end else begin
      kh[ri(0)] = key[2:1];
      sh[ri(0)] = sw;
      s_now  = sh[ri(1)];
      s_old  = sh[ri(2)];
      m_tick = 1'b0;
      if (m_run) begin
        if (s_now != s_old) next_tick = cyc + period(int'(s_now));
        else if (cyc == next_tick) begin
          m_tick    = 1'b1;
          next_tick = cyc + period(int'(s_now));
        end
        if (prs[1]) m_run = 1'b0;
      end else begin
        if (prs[1]) begin
          m_run     = 1'b1;
          next_tick = cyc + period(int'(s_now));
        end else if (prs[0]) begin
          m_tick = 1'b1;
        end
      end
      // A key is accepted once its last DB synchronised samples all disagree
      // with the accepted level.
      for (int b = 0; b < 2; b++) begin
        flip = 1'b1;
        for (int k = 0; k < DB; k++)
          if (kh[ri(2 + k)][b] == lvl[b]) flip = 1'b0;
        prs[b] = 1'b0;
        if (flip) begin
          lvl[b] = ~lvl[b];
          prs[b] = ~lvl[b];
        end
      end
    end
  end

  // Compare on every falling edge.
  always @(negedge clk) begin
    if (key[0] == 1'b0) begin
      check("tick_in_reset", tick, 0);
      check("running_in_reset", running, 1);
    end else begin
      check("tick_vs_model", tick, m_tick);
      check("running_vs_model", running, m_run);
    end
  end

  // ---------------------------------------------------------------------------
  // Bounded wait helpers (count falling edges until the condition holds)
  // ---------------------------------------------------------------------------
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < limit);
    if (tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_tick: no tick within %0d cycles", limit);
    end
  endtask

  task automatic wait_run(input logic val, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running !== val && n < limit);
    if (running !== val) begin
      tests++;
      fails++;
      $display("FAIL wait_run: running not %0d within %0d cycles", val, limit);
    end
  endtask

  task automatic count_ticks(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tick === 1'b1) c++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int n;
  int c;

  initial begin
    key = 3'b110;
    sw  = 2'd0;
    repeat (8) @(negedge clk);
    check("reset_running", running, 1);
    check("reset_tick", tick, 0);

    // Reset release: rst_n high after edge 2, first tick 100 edges later.
    key[0] = 1'b1;
    wait_tick(300, n);
    check("first_tick_after_reset", n, 102);
    wait_tick(300, n);
    check("run_period_s0", n, 100);

    // Glitch of 3 cycles on the toggle key: rejected.
    @(negedge clk);
    key[2] = 1'b0;
    repeat (3) @(negedge clk);
    key[2] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_ignored", running, 1);

    // Real press: 2 sync + 4 debounce + 1 FSM.
    key[2] = 1'b0;
    wait_run(1'b0, 20, n);
    check("toggle_to_pause_latency", n, 7);
    key[2] = 1'b1;
    count_ticks(150, c);
    check("pause_no_ticks", c, 0);

    // Three step presses, one tick each.
    for (int i = 0; i < 3; i++) begin
      key[1] = 1'b0;
      wait_tick(20, n);
      check("step_latency", n, 7);
      key[1] = 1'b1;
      @(negedge clk);
      check("step_single_cycle", tick, 0);
      repeat (10) @(negedge clk);
    end

    // Resume, then change speed 0 -> 3 partway through the period.
    key[2] = 1'b0;
    wait_run(1'b1, 20, n);
    check("toggle_to_run_latency", n, 7);
    key[2] = 1'b1;
    repeat (58) @(negedge clk);
    sw = 2'd3;
    wait_tick(50, n);
    check("speed_change_first_tick", n, 14);
    wait_tick(50, n);
    check("run_period_s3", n, 12);

    // Pause, restore speed 0, then toggle+step on the same cycle.
    key[2] = 1'b0;
    wait_run(1'b0, 20, n);
    key[2] = 1'b1;
    sw = 2'd0;
    repeat (12) @(negedge clk);
    key[2] = 1'b0;
    key[1] = 1'b0;
    wait_run(1'b1, 20, n);
    check("toggle_step_latency", n, 7);
    check("toggle_step_no_tick", tick, 0);
    key[2] = 1'b1;
    key[1] = 1'b1;
    wait_tick(200, n);
    check("first_tick_after_resume", n, 100);

    // Toggle press landing on the terminal count.
    repeat (93) @(negedge clk);
    key[2] = 1'b0;
    repeat (7) @(negedge clk);
    check("terminal_tick_kept", tick, 1);
    check("terminal_enters_pause", running, 0);
    key[2] = 1'b1;
    @(negedge clk);
    check("terminal_tick_single", tick, 0);

    // Reset asserted while a step tick is high, in PAUSE.
    repeat (10) @(negedge clk);
    key[1] = 1'b0;
    wait_tick(20, n);
    #1 key[0] = 1'b0;
    #1;
    check("async_reset_tick", tick, 0);
    check("async_reset_running", running, 1);
    key[1] = 1'b1;
    repeat (4) @(negedge clk);
    key[0] = 1'b1;
    wait_tick(300, n);
    check("tick_after_mid_reset", n, 102);
    wait_tick(300, n);
    check("period_after_mid_reset", n, 100);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_tick_ctrl
